// File: rtl/scratch_arb_pkg.sv
// Shared definitions for the scratch memory arbiter: port ids, FSM encoding, default widths
// and the winner-selection helper.
package scratch_arb_pkg;

  localparam logic [1:0] PORT_HIST = 2'd0;
  localparam logic [1:0] PORT_CDF  = 2'd1;
  localparam logic [1:0] PORT_DIV  = 2'd2;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 20;

  typedef enum logic {
    StArb   = 1'b0,
    StOwned = 1'b1
  } arb_state_e;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p == PORT_DIV) ? PORT_HIST : p + 2'd1;
  endfunction

  // Returns {found, id}. Search starts at 'start'; a demoted port is only picked when it is the
  // sole requester.
  function automatic logic [2:0] pick_winner(input logic [2:0] req, input logic [1:0] start,
                                             input logic demote_en, input logic [1:0] demote_id);
    logic [2:0] res;
    logic [2:0] s;
    res = 3'b000;
    for (int i = 0; i < 3; i++) begin
      s = {1'b0, start} + 3'(i);
      if (s >= 3'd3) s = s - 3'd3;
      if (!res[2] && req[s[1:0]] && !(demote_en && s[1:0] == demote_id)) begin
        res = {1'b1, s[1:0]};
      end
    end
    if (!res[2] && demote_en && req[demote_id]) res = {1'b1, demote_id};
    return res;
  endfunction

endpackage

// File: rtl/scratch_arb_rd_tag_pipe.sv
// Read-tag delay line: carries {valid, port id} of each issued read for the SRAM read latency.
module scratch_arb_rd_tag_pipe #(
  parameter int unsigned Depth = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push_valid,
  input  logic [1:0] push_id,
  output logic       pop_valid,
  output logic [1:0] pop_id
);

  logic [Depth-1:0] vld_q;
  logic [1:0]       id_q [Depth];

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int i = 0; i < Depth; i++) id_q[i] <= 2'd0;
    end else begin
      vld_q[0] <= push_valid;
      id_q[0]  <= push_id;
      for (int i = 1; i < Depth; i++) begin
        vld_q[i] <= vld_q[i-1];
        id_q[i]  <= id_q[i-1];
      end
    end
  end

  assign pop_valid = vld_q[Depth-1];
  assign pop_id    = id_q[Depth-1];

endmodule

// File: rtl/scratch_mem_arbiter.sv
// Three-port scratch SRAM arbiter with lock bursts, forced-release watchdog and read return.
// Define SCRATCH_ARB_ROUND_ROBIN_EN for round-robin; fixed priority port0 > 1 > 2 otherwise.
module scratch_mem_arbiter
  import scratch_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [2:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lock_timeout
);

  localparam int unsigned CntW = $clog2(LOCK_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [CntW-1:0]   lock_cnt_q, lock_cnt_d, cnt_inc;
  logic              demote_vld_q, demote_vld_d;
  logic [1:0]        demote_id_q, demote_id_d;
  logic [ADDR_W-1:0] addr_hold_q, sel_addr;
  logic [DATA_W-1:0] wdata_hold_q, sel_wdata, rdata_q;
  logic [2:0]        rvalid_q, pick;
  logic [1:0]        win, arb_start, pop_id;
  logic              gnt_vld, arb_gnt, arb_en, pop_valid;

`ifdef SCRATCH_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;

  assign arb_start = rr_ptr_q;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (arb_gnt) rr_ptr_d = next_port(win);
    else if (state_q == StOwned && state_d == StArb) rr_ptr_d = next_port(owner_q);
  end

  always_ff @(posedge clock) begin
    if (reset) rr_ptr_q <= 2'd0;
    else       rr_ptr_q <= rr_ptr_d;
  end
`else
  assign arb_start = PORT_HIST;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lock_cnt_d   = lock_cnt_q;
    demote_vld_d = demote_vld_q;
    demote_id_d  = demote_id_q;
    gnt_vld      = 1'b0;
    win          = PORT_HIST;
    arb_gnt      = 1'b0;
    arb_en       = 1'b0;
    lock_timeout = 1'b0;
    pick         = 3'b000;
    cnt_inc      = lock_cnt_q + CntW'(1);
    if (state_q == StOwned) begin
      if (req[owner_q]) begin
        gnt_vld    = 1'b1;
        win        = owner_q;
        lock_cnt_d = cnt_inc;
        if (!lock[owner_q] || cnt_inc >= CntW'(LOCK_MAX)) begin
          state_d    = StArb;
          lock_cnt_d = '0;
        end
        if (lock[owner_q] && cnt_inc >= CntW'(LOCK_MAX)) begin
          lock_timeout = 1'b1;
          demote_vld_d = 1'b1;
          demote_id_d  = owner_q;
        end
      end else begin
        // Owner went idle: hand the slot to the others this cycle so there is no bubble.
        state_d    = StArb;
        lock_cnt_d = '0;
        arb_en     = 1'b1;
      end
    end else begin
      arb_en = 1'b1;
    end
    if (arb_en) begin
      pick = pick_winner(req, arb_start, demote_vld_q, demote_id_q);
      if (pick[2]) begin
        gnt_vld      = 1'b1;
        win          = pick[1:0];
        arb_gnt      = 1'b1;
        demote_vld_d = 1'b0;
        if (lock[win] && LOCK_MAX > 1) begin
          state_d    = StOwned;
          owner_d    = win;
          lock_cnt_d = CntW'(1);
        end
      end
    end
    if (reset) begin
      gnt_vld      = 1'b0;
      lock_timeout = 1'b0;
    end
  end

  always_comb begin
    sel_addr  = addr0;
    sel_wdata = wdata0;
    case (win)
      PORT_HIST: begin
        sel_addr  = addr0;
        sel_wdata = wdata0;
      end
      PORT_CDF: begin
        sel_addr  = addr1;
        sel_wdata = wdata1;
      end
      PORT_DIV: begin
        sel_addr  = addr2;
        sel_wdata = wdata2;
      end
      default: ;
    endcase
  end

  assign gnt       = gnt_vld ? (3'b001 << win) : 3'b000;
  assign mem_en    = gnt_vld;
  assign mem_we    = gnt_vld & we[win];
  assign mem_addr  = gnt_vld ? sel_addr : addr_hold_q;
  assign mem_wdata = gnt_vld ? sel_wdata : wdata_hold_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;

  scratch_arb_rd_tag_pipe #(
    .Depth(RD_LAT)
  ) u_rd_tag_pipe (
    .clock     (clock),
    .reset     (reset),
    .push_valid(gnt_vld & ~we[win]),
    .push_id   (win),
    .pop_valid (pop_valid),
    .pop_id    (pop_id)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StArb;
      owner_q      <= PORT_HIST;
      lock_cnt_q   <= '0;
      demote_vld_q <= 1'b0;
      demote_id_q  <= PORT_HIST;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      rvalid_q     <= 3'b000;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lock_cnt_q   <= lock_cnt_d;
      demote_vld_q <= demote_vld_d;
      demote_id_q  <= demote_id_d;
      if (gnt_vld) begin
        addr_hold_q  <= mem_addr;
        wdata_hold_q <= mem_wdata;
      end
      rvalid_q <= pop_valid ? (3'b001 << pop_id) : 3'b000;
      if (pop_valid) rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// Directed self-checking bench for scratch_mem_arbiter (RD_LAT=1, LOCK_MAX=16) with an SRAM model.
module tb_scratch_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, we, gnt, rvalid;
  logic [7:0]  addr0, addr1, addr2, mem_addr;
  logic [19:0] wdata0, wdata1, wdata2, rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we, lock_timeout;
  logic [19:0] sram [256];

  int total  = 0;
  int passed = 0;

  always #5 clock = ~clock;

  scratch_mem_arbiter #(
    .ADDR_W  (8),
    .DATA_W  (20),
    .RD_LAT  (1),
    .LOCK_MAX(16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .lock        (lock),
    .we          (we),
    .addr0       (addr0),
    .addr1       (addr1),
    .addr2       (addr2),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .wdata2      (wdata2),
    .gnt         (gnt),
    .rvalid      (rvalid),
    .rdata       (rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .lock_timeout(lock_timeout)
  );

  // One-cycle SRAM; contents are a known pattern, reloaded while reset is high.
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) sram[i] <= 20'(i) * 20'd7 + 20'd1;
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  function automatic logic [19:0] exp_data(input logic [2:0] oh);
    logic [7:0] a;
    a = oh[0] ? addr0 : (oh[1] ? addr1 : addr2);
    return {12'd0, a} * 20'd7 + 20'd1;
  endfunction

  task automatic idle_inputs();
    req = 3'b000; lock = 3'b000; we = 3'b000;
    addr0 = 8'h10; addr1 = 8'h21; addr2 = 8'h32;
    wdata0 = 20'h0; wdata1 = 20'h0; wdata2 = 20'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    req = 3'b111;
    #1;
    total++;
    if (gnt !== 3'b000) $display("FAIL reset_gnt: got %b want 000", gnt); else passed++;
    total++;
    if (rvalid !== 3'b000) $display("FAIL reset_rvalid: got %b want 000", rvalid); else passed++;
    total++;
    if (rdata !== 20'h0) $display("FAIL reset_rdata: got %h want 0", rdata); else passed++;
    total++;
    if ({mem_en, mem_we, lock_timeout} !== 3'b000)
      $display("FAIL reset_ctrl: got en/we/to %b want 000", {mem_en, mem_we, lock_timeout});
    else passed++;
    total++;
    if (mem_addr !== 8'h00) $display("FAIL reset_mem_addr: got %h want 00", mem_addr); else passed++;
    total++;
    if (mem_wdata !== 20'h0) $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata);
    else passed++;
    req = 3'b000;
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_arbitration();
    logic [2:0] exp_g [6];
`ifdef SCRATCH_ARB_ROUND_ROBIN_EN
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    exp_g[3] = 3'b001; exp_g[4] = 3'b010; exp_g[5] = 3'b100;
`else
    for (int i = 0; i < 6; i++) exp_g[i] = 3'b001;
`endif
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req = (c < 6) ? 3'b111 : 3'b000;
      #1;
      total++;
      if (gnt !== ((c < 6) ? exp_g[c] : 3'b000))
        $display("FAIL arb_gnt c%0d: got %b want %b", c, gnt, (c < 6) ? exp_g[c] : 3'b000);
      else passed++;
      if (c >= 2) begin
        total++;
        if (rvalid !== exp_g[c-2])
          $display("FAIL arb_rvalid c%0d: got %b want %b", c, rvalid, exp_g[c-2]);
        else passed++;
        total++;
        if (rdata !== exp_data(exp_g[c-2]))
          $display("FAIL arb_rdata c%0d: got %h want %h", c, rdata, exp_data(exp_g[c-2]));
        else passed++;
      end else begin
        total++;
        if (rvalid !== 3'b000) $display("FAIL arb_rvalid c%0d: got %b want 000", c, rvalid);
        else passed++;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      req  = (c < 5) ? 3'b101 : 3'b100;
      lock = (c < 5) ? 3'b001 : 3'b000;
      #1;
      total++;
      if (gnt !== ((c < 5) ? 3'b001 : 3'b100))
        $display("FAIL lock_gnt c%0d: got %b want %b", c, gnt, (c < 5) ? 3'b001 : 3'b100);
      else passed++;
      @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int c = 0; c < 17; c++) begin
      req  = (c == 0) ? 3'b010 : 3'b110;
      lock = 3'b010;
      #1;
      total++;
      if (gnt !== ((c < 16) ? 3'b010 : 3'b100))
        $display("FAIL wdog_gnt c%0d: got %b want %b", c, gnt, (c < 16) ? 3'b010 : 3'b100);
      else passed++;
      total++;
      if (lock_timeout !== (c == 15))
        $display("FAIL wdog_timeout c%0d: got %b want %b", c, lock_timeout, (c == 15));
      else passed++;
      @(negedge clock);
    end
    idle_inputs();
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_write_read();
    do_reset();
    req = 3'b001; we = 3'b001; addr0 = 8'h05; wdata0 = 20'h00003;
    #1;
    total++;
    if ({gnt, mem_we} !== 4'b0011) $display("FAIL wr_gnt_we: got %b want 0011", {gnt, mem_we});
    else passed++;
    total++;
    if ({mem_addr, mem_wdata} !== {8'h05, 20'h00003})
      $display("FAIL wr_cmd: got %h/%h want 05/00003", mem_addr, mem_wdata);
    else passed++;
    @(negedge clock);
    req = 3'b010; we = 3'b000; addr1 = 8'h05;
    #1;
    total++;
    if ({gnt, mem_we, mem_addr} !== {3'b010, 1'b0, 8'h05})
      $display("FAIL rd_cmd: got %b/%b/%h want 010/0/05", gnt, mem_we, mem_addr);
    else passed++;
    for (int c = 1; c < 5; c++) begin
      if (c > 1) begin
        req = 3'b000;
        @(negedge clock);
      end else begin
        @(negedge clock);
        req = 3'b000;
      end
      #1;
      total++;
      if (rvalid !== ((c == 2) ? 3'b010 : 3'b000))
        $display("FAIL wr_rd_rvalid c%0d: got %b want %b", c, rvalid,
                 (c == 2) ? 3'b010 : 3'b000);
      else passed++;
      if (c == 2) begin
        total++;
        if (rdata !== 20'h00003) $display("FAIL wr_rd_rdata: got %h want 00003", rdata);
        else passed++;
      end
    end
    @(negedge clock);
    idle_inputs();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    req = 3'b001; lock = 3'b001;
    #1;
    total++;
    if (gnt !== 3'b001) $display("FAIL rif_gnt0: got %b want 001", gnt); else passed++;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1; req = 3'b111;
    #1;
    total++;
    if (gnt !== 3'b000) $display("FAIL rif_gnt_in_reset: got %b want 000", gnt); else passed++;
    @(negedge clock);
    reset = 1'b0; req = 3'b100; lock = 3'b000;
    #1;
    total++;
    if (gnt !== 3'b100) $display("FAIL rif_gnt_after: got %b want 100", gnt); else passed++;
    total++;
    if ({rvalid, rdata} !== 23'd0)
      $display("FAIL rif_squash: got rvalid %b rdata %h want 000/0", rvalid, rdata);
    else passed++;
    @(negedge clock);
    req = 3'b000;
    #1;
    total++;
    if (rvalid !== 3'b000) $display("FAIL rif_rvalid_c4: got %b want 000", rvalid); else passed++;
    @(negedge clock);
    #1;
    total++;
    if (rvalid !== 3'b100) $display("FAIL rif_rvalid_c5: got %b want 100", rvalid); else passed++;
    total++;
    if (rdata !== exp_data(3'b100))
      $display("FAIL rif_rdata: got %h want %h", rdata, exp_data(3'b100));
    else passed++;
    @(negedge clock);
  endtask

  task automatic test_idle();
    idle_inputs();
    req = 3'b010;
    @(negedge clock);
    req = 3'b000;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if ({gnt, mem_en, mem_we} !== 5'b00000)
        $display("FAIL idle_ctrl c%0d: got gnt %b en %b we %b want 0", c, gnt, mem_en, mem_we);
      else passed++;
      total++;
      if (mem_addr !== 8'h21) $display("FAIL idle_addr_hold c%0d: got %h want 21", c, mem_addr);
      else passed++;
      @(negedge clock);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_arbitration();
    test_lock();
    test_watchdog();
    test_write_read();
    test_reset_inflight();
    test_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL time_limit: got no finish by 200000 want finish");
    $fatal(1);
  end

endmodule

// File: doc/scratch_mem_arbiter.md
# scratch_mem_arbiter

Shares the single-port scratch memory (histogram/CDF bins) among three requesters: histogram unit (port 0), CDF unit (port 1), divider (port 2). Per-port req/gnt handshake, a lock for read-modify-write bursts with a forced-release watchdog, and per-port read-data-valid return after the fixed memory latency. Sits between the compute units and the scratch SRAM, alongside the top-level sequencing FSM.

## Interface
- ADDR_W, 8, scratch address width (256 bins)
- DATA_W, 20, scratch word width
- RD_LAT, 1, SRAM read latency in cycles (1..4)
- LOCK_MAX, 16, maximum consecutive locked grants before forced release
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- req[2:0]  in  3  per-port access request
- lock[2:0]  in  3  per-port hold-ownership request, meaningful only with req
- we[2:0]  in  3  per-port write enable
- addr0/addr1/addr2  in  ADDR_W each  per-port address
- wdata0/wdata1/wdata2  in  DATA_W each  per-port write data
- gnt[2:0]  out  3  one-hot grant, same cycle as the accepted access
- rvalid[2:0]  out  3  read data valid for the port that issued the read
- rdata  out  DATA_W  shared read data (registered copy of mem_rdata)
- mem_en, mem_we  out  1 each  SRAM command
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W
- mem_rdata  in  DATA_W  SRAM read data, RD_LAT cycles after mem_en
- lock_timeout  out  1  one-cycle pulse when the watchdog forces a release

## Operation
- FSM states: ARB (no owner), OWNED (owner holds lock).
- ARB: if any req, pick winner by policy (see Configuration), assert gnt[winner], drive mem_* from winner's inputs combinationally. If winner also has lock=1, go OWNED, owner=winner, lock_cnt=1.
- OWNED: only owner can be granted. Owner req=1 -> granted regardless of other reqs; lock_cnt increments. Owner drops req or lock -> access (if req) granted this cycle, next state ARB. Other requesters wait, gnt stays 0.
- Watchdog: in OWNED, a grant that brings lock_cnt to LOCK_MAX is the owner's last; next state ARB, lock_timeout pulses that cycle, owner becomes lowest priority for the next arbitration in both policies.
- No req anywhere: gnt=0, mem_en=0, mem_we=0; mem_addr/mem_wdata hold last value.
- Reads: granted access with we=0 pushes port id into an RD_LAT-deep tag pipeline; on exit rdata<=mem_rdata, rvalid[id]=1 one cycle. Writes push nothing.
- Back-to-back reads from different ports return in issue order, one per cycle.
- Read-after-write to same address by owner in consecutive cycles is the SRAM's responsibility; arbiter adds no forwarding.

## Timing
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, lock_timeout=0, state ARB, rr pointer=port 0, lock_cnt=0, tag pipeline empty.
- gnt is combinational from req/state; requester treats req&gnt at the rising edge as transfer complete.
- Read latency request-to-rvalid: RD_LAT+1 cycles (RD_LAT SRAM + 1 rdata register).
- Full throughput: one access per cycle, no bubbles on owner change.
- reset asserted mid-burst or with reads in flight: all in-flight rvalid squashed, ownership dropped, outputs to reset values next edge.
- lock without req is ignored; lock asserted by non-owner while OWNED is ignored.

## Configuration
- SCRATCH_ARB_ROUND_ROBIN_EN defined: round-robin; pointer moves to (winner+1) mod 3 after every ARB-state grant and after each OWNED release; search starts at pointer.
- Not defined: fixed priority port0 > port1 > port2; pointer logic absent; watchdog release still demotes the released owner for exactly one arbitration.

## Structure
- Shared package scratch_arb_pkg: port index constants PORT_HIST=0, PORT_CDF=1, PORT_DIV=2, state encoding ARB/OWNED, default ADDR_W/DATA_W.
- One sub-module: scratch_arb_rd_tag_pipe (RD_LAT-deep valid+2-bit id shift register with synchronous clear).

## Test plan
- Reset, then req=3'b111, no lock, all reads -> grants in order 0,1,2,0 (RR) or 0,0,0 (fixed); rvalid per port 2 cycles after each grant (RD_LAT=1).
- Port 0 req+lock for 5 cycles while port 2 requests -> gnt=001 for 5 cycles, gnt=100 on cycle 6.
- Port 1 holds lock 20 cycles, LOCK_MAX=16 -> 16 grants, lock_timeout pulse on 16th, next grant to port 0 or 2.
- Port 0 write addr 8'h05 data 20'h00003 then port 1 read 8'h05 -> rvalid[1]=1, rdata=20'h00003, rvalid[0] never set.
- Reset asserted with two reads in flight -> no rvalid after reset, gnt=0, state ARB.
- No requests for 10 cycles -> mem_en=0, gnt=0 every cycle.
